seg_scan_driver: RTL and testbench



---
 rtl/seg_pkg.sv | 55 +++++
 rtl/seg7_decode.sv | 46 ++++
 rtl/seg_scan_driver.sv | 151 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
//   Shared constants and small helpers for the seven-segment display stage.
//   Segment patterns are active-high, ordered {g,f,e,d,c,b,a}.
//
//   Contents:
//     BLANK_CODE      digit code that renders as an unlit digit
//     SEG_0..SEG_E    hex glyphs for codes 0..E
//     SEG_OFF         all segments unlit
//     IDX_W           width of the digit scan index
//     NUM_DIGITS      number of multiplexed digits on the board
//     digit_t         one 4-bit digit code
//     digit_idx_t     scan index type
//     idxToOnehot     scan index -> one-hot anode vector (active-high)
//     isLeadCandidate true for codes that still count as "leading" (0 or blank)
// ---------------------------------------------------------------------------
package seg_pkg;

  localparam int IDX_W      = 2;
  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_OFF = 7'h00;

  typedef logic [3:0]       digit_t;
  typedef logic [IDX_W-1:0] digit_idx_t;

  // Turns the scan index into the active-high anode vector for that digit.
  function automatic logic [NUM_DIGITS-1:0] idxToOnehot(input digit_idx_t idx);
    return 4'b0001 << idx;
  endfunction

  // A digit above the one being considered keeps the "leading" run going
  // only if it is zero or already blank; any real glyph ends the run.
  function automatic logic isLeadCandidate(input digit_t value);
    return (value == 4'h0) || (value == BLANK_CODE);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
//   Purely combinational hex-to-seven-segment decoder, active-high output.
//   Code BLANK_CODE (4'hF) renders dark, as does any code when blank_i is set,
//   so callers can force a digit off without rewriting its value.
//
//   Ports:
//     value_i  [3:0]  digit code 0..F
//     blank_i         1 = force the digit dark
//     seg_o    [6:0]  active-high segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] value_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Glyph lookup. The blank request wins over the table so a suppressed
  // zero never lights up, and code F maps to dark in the table itself.
  always_comb begin
    seg_o = SEG_OFF;
    if (!blank_i) begin
      unique case (value_i)
        4'h0:    seg_o = SEG_0;
        4'h1:    seg_o = SEG_1;
        4'h2:    seg_o = SEG_2;
        4'h3:    seg_o = SEG_3;
        4'h4:    seg_o = SEG_4;
        4'h5:    seg_o = SEG_5;
        4'h6:    seg_o = SEG_6;
        4'h7:    seg_o = SEG_7;
        4'h8:    seg_o = SEG_8;
        4'h9:    seg_o = SEG_9;
        4'hA:    seg_o = SEG_A;
        4'hB:    seg_o = SEG_B;
        4'hC:    seg_o = SEG_C;
        4'hD:    seg_o = SEG_D;
        4'hE:    seg_o = SEG_E;
        default: seg_o = SEG_OFF;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//   Drives a 4-digit multiplexed seven-segment display from four BCD/hex
//   digit inputs. One digit is lit per slot of REFRESH_COUNT cycles; the
//   first GUARD_CYCLES of each slot keep every anode off so the previous
//   digit's segments never ghost onto the next one. Inputs are captured once
//   per frame (the last cycle of slot 3) so a frame is always consistent.
//
//   Parameters:
//     REFRESH_COUNT  clock cycles per digit slot
//     GUARD_CYCLES   anode-off cycles at the start of each slot (< REFRESH_COUNT)
//     ACTIVE_LOW     1 = common-anode board, outputs driven low to light
//
//   Ports:
//     clk         system clock
//     rst         synchronous, active-high reset
//     bcd0..bcd3  digit codes, bcd0 rightmost, 4'hF = blank
//     dp_in       decimal point request, bit i = digit i
//     blank_lead  1 = suppress leading zeros
//     an          digit enables, bit i = digit i
//     seg         segments {g,f,e,d,c,b,a}
//     dp          decimal point segment
// ---------------------------------------------------------------------------
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_COUNT = 27'd125_000,
  parameter int unsigned GUARD_CYCLES  = 2,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd3,
  input  logic [3:0] dp_in,
  input  logic       blank_lead,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int              CNT_W     = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_COUNT - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);

  // XOR masks that flip the internal active-high view into board polarity.
  // They are also the reset values, since "all off" is all-zero internally.
  localparam logic [3:0] AN_POL  = ACTIVE_LOW ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_POL = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_POL  = ACTIVE_LOW ? 1'b1  : 1'b0;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  digit_idx_t            idx_q, idx_d;
  logic [3:0][3:0]       shadowDig_q, shadowDig_d;
  logic [3:0]            shadowDp_q, shadowDp_d;
  logic [3:0]            an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  slotEnd;
  logic                  frameEnd;
  logic [3:0]            suppress;
  digit_t                curDigit;
  logic                  curSuppress;
  logic [6:0]            curPattern;
  logic                  inGuard;

  // Slot timing: cnt walks through one slot, and each wrap moves the scan
  // to the next digit. The frame ends on the final cycle of digit 3, which
  // is the only moment the shadow copy of the inputs is refreshed.
  always_comb begin
    slotEnd     = (cnt_q == CNT_LAST);
    frameEnd    = slotEnd && (idx_q == digit_idx_t'(NUM_DIGITS - 1));
    cnt_d       = slotEnd ? '0 : cnt_q + CNT_W'(1);
    idx_d       = slotEnd ? idx_q + digit_idx_t'(1) : idx_q;
    shadowDig_d = shadowDig_q;
    shadowDp_d  = shadowDp_q;
    if (frameEnd) begin
      shadowDig_d = {bcd3, bcd2, bcd1, bcd0};
      shadowDp_d  = dp_in;
    end
  end

  // Leading-zero suppression works only on the frame's shadow values, so
  // mid-frame input changes cannot make a digit blink. A digit goes dark if
  // it is zero and everything to its left is zero or blank; the rightmost
  // digit always shows so a value of zero still reads "0".
  always_comb begin
    suppress    = 4'b0000;
    suppress[3] = blank_lead && (shadowDig_q[3] == 4'h0);
    suppress[2] = blank_lead && (shadowDig_q[2] == 4'h0)
                  && isLeadCandidate(shadowDig_q[3]);
    suppress[1] = blank_lead && (shadowDig_q[1] == 4'h0)
                  && isLeadCandidate(shadowDig_q[3])
                  && isLeadCandidate(shadowDig_q[2]);
  end

  // Pick the digit for the current slot and hand it to the decoder.
  // Code F is blanked inside the decoder; suppression is passed as a flag.
  always_comb begin
    curDigit    = shadowDig_q[idx_q];
    curSuppress = suppress[idx_q];
  end

  seg7_decode uDecode (
    .value_i (curDigit),
    .blank_i (curSuppress),
    .seg_o   (curPattern)
  );

  // Next output values. During the guard window the anodes are dark while
  // seg/dp already carry the new digit, so the segment lines settle before
  // any anode turns on. A suppressed digit must not leave a stray point lit.
  // Polarity is applied here so the registers drive the pins directly.
  always_comb begin
    inGuard = (cnt_q < GUARD_END);
    an_d    = (inGuard ? 4'h0 : idxToOnehot(idx_q)) ^ AN_POL;
    seg_d   = curPattern ^ SEG_POL;
    dp_d    = (shadowDp_q[idx_q] && !curSuppress) ^ DP_POL;
  end

  // All state in one place. Reset parks the scan at digit 0, blanks the
  // shadow so the first frame after reset is dark, and drives every output
  // to its unlit level.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadowDig_q <= {NUM_DIGITS{BLANK_CODE}};
      shadowDp_q  <= 4'h0;
      an_q        <= AN_POL;
      seg_q       <= SEG_POL;
      dp_q        <= DP_POL;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadowDig_q <= shadowDig_d;
      shadowDp_q  <= shadowDp_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
//   Self-checking bench for seg_scan_driver with REFRESH_COUNT=4,
//   GUARD_CYCLES=1, ACTIVE_LOW=1. Every cycle is compared against a
//   behavioural model derived from the display rules; a table of
//   hand-computed frames and a few hand-written sequences add independent
//   expected values.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int RC    = 4;
  localparam int GUARD = 1;
  localparam int FRAME = 4 * RC;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h00
  };

  localparam logic [3:0] AN_SEQ [16] = '{
    4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
    4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7
  };

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bcd0, bcd1, bcd2, bcd3;
  logic [3:0] dp_in;
  logic       blank_lead;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int          total = 0;
  int          bad   = 0;
  int          s     = 0;
  logic [15:0] mDig  = 16'hFFFF;
  logic [3:0]  mDp   = 4'h0;

  typedef struct {
    logic [3:0]      b3, b2, b1, b0;
    logic [3:0]      dpv;
    logic            bl;
    logic [3:0][6:0] segExp;
    logic [3:0]      dpExp;
  } vec_t;

  vec_t vecs [8];

  seg_scan_driver #(
    .REFRESH_COUNT (RC),
    .GUARD_CYCLES  (GUARD),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd0       (bcd0),
    .bcd1       (bcd1),
    .bcd2       (bcd2),
    .bcd3       (bcd3),
    .dp_in      (dp_in),
    .blank_lead (blank_lead),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  // Reference model: what the pins should show for a given cycle of the
  // frame, given the latched digits, latched points and the live blank_lead.
  function automatic logic [11:0] modelOut(input int st, input logic [15:0] digs,
                                           input logic [3:0] dpv, input logic bl);
    int         slot;
    int         pos;
    logic [3:0] val;
    logic [3:0] higher;
    logic       sup;
    logic [6:0] pat;
    logic [3:0] anAct;
    logic       dpOn;
    slot = (st / RC) % 4;
    pos  = st % RC;
    val  = digs[slot*4 +: 4];
    sup  = bl && (slot > 0) && (val == 4'h0);
    for (int j = slot + 1; j < 4; j++) begin
      higher = digs[j*4 +: 4];
      if (higher != 4'h0 && higher != 4'hF) sup = 1'b0;
    end
    pat   = (val == 4'hF || sup) ? 7'h00 : SEG_TABLE[val];
    dpOn  = dpv[slot] && !sup;
    anAct = (pos < GUARD) ? 4'h0 : 4'(1 << slot);
    return ~{anAct, pat, dpOn};
  endfunction

  // One comparison: counts it, and reports the values when they differ.
  task automatic checkOutput(input string name, input logic [11:0] got,
                             input logic [11:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s @state %0d: got an/seg/dp=%h want %h", name, s, got, want);
    end
  endtask

  // Inputs change just after a rising edge, well clear of the sampling edge.
  task automatic applyStimulus(input logic [3:0] b3, input logic [3:0] b2,
                               input logic [3:0] b1, input logic [3:0] b0,
                               input logic [3:0] dpv, input logic bl);
    bcd3       = b3;
    bcd2       = b2;
    bcd1       = b1;
    bcd0       = b0;
    dp_in      = dpv;
    blank_lead = bl;
  endtask

  // Advance one clock, checking the registered outputs against the model
  // for the cycle that just ended, then update the model's latched frame.
  task automatic stepCycle();
    logic [11:0] expv;
    logic        wasRst;
    logic        doLatch;
    logic [15:0] capDig;
    logic [3:0]  capDp;
    wasRst  = rst;
    capDig  = {bcd3, bcd2, bcd1, bcd0};
    capDp   = dp_in;
    expv    = wasRst ? 12'hFFF : modelOut(s, mDig, mDp, blank_lead);
    doLatch = !wasRst && ((s % FRAME) == FRAME - 1);
    @(posedge clk);
    #1;
    checkOutput("cycle", {an, seg, dp}, expv);
    if (wasRst) begin
      s    = 0;
      mDig = 16'hFFFF;
      mDp  = 4'h0;
    end else begin
      if (doLatch) begin
        mDig = capDig;
        mDp  = capDp;
      end
      s++;
    end
  endtask

  // Run up to the next frame boundary so inputs already applied are latched.
  task automatic syncFrame();
    do stepCycle(); while ((s % FRAME) != 0);
  endtask

  initial begin
    vecs[0] = '{4'h1, 4'hF, 4'h0, 4'h7, 4'b0000, 1'b0, {7'h79, 7'h7F, 7'h40, 7'h78}, 4'b1111};
    vecs[1] = '{4'h0, 4'h0, 4'h0, 4'h5, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1111};
    vecs[2] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    vecs[3] = '{4'h1, 4'hF, 4'h0, 4'h3, 4'b0000, 1'b1, {7'h79, 7'h7F, 7'h40, 7'h30}, 4'b1111};
    vecs[4] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'b0010, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1101};
    vecs[5] = '{4'h0, 4'h0, 4'h0, 4'h8, 4'b0010, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h00}, 4'b1111};
    vecs[6] = '{4'hA, 4'hB, 4'hC, 4'hE, 4'b0000, 1'b0, {7'h08, 7'h03, 7'h46, 7'h06}, 4'b1111};
    vecs[7] = '{4'h0, 4'hF, 4'h0, 4'hD, 4'b1111, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h21}, 4'b1010};

    rst = 1'b1;
    applyStimulus(4'h2, 4'h3, 4'h4, 4'h5, 4'hF, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("resetState", {an, seg, dp}, 12'hFFF);

    // First frame after reset is dark and scans in the fixed anode order.
    applyStimulus(4'h1, 4'hF, 4'h0, 4'h7, 4'h0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      stepCycle();
      checkOutput("firstFrame", {an, seg, dp}, {AN_SEQ[k], 7'h7F, 1'b1});
    end

    // Table of whole frames with hand-derived glyphs per slot.
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].b3, vecs[v].b2, vecs[v].b1, vecs[v].b0,
                    vecs[v].dpv, vecs[v].bl);
      syncFrame();
      for (int k = 0; k < FRAME; k++) begin
        stepCycle();
        if ((k % RC) == RC - 1)
          checkOutput($sformatf("vec%0d_slot%0d", v, k / RC), {an, seg, dp},
                      {4'hF ^ 4'(1 << (k / RC)), vecs[v].segExp[k / RC],
                       vecs[v].dpExp[k / RC]});
      end
    end

    // Mid-frame input change must wait for the frame boundary.
    applyStimulus(4'h0, 4'h5, 4'h0, 4'h3, 4'h0, 1'b0);
    syncFrame();
    for (int k = 0; k < 5; k++) begin
      stepCycle();
      if (k == 3) checkOutput("midOld0", {an, seg, dp}, {4'hE, 7'h30, 1'b1});
    end
    applyStimulus(4'h0, 4'h8, 4'h0, 4'h9, 4'h0, 1'b0);
    for (int k = 5; k < FRAME; k++) begin
      stepCycle();
      if (k == 11) checkOutput("midOld2", {an, seg, dp}, {4'hB, 7'h12, 1'b1});
    end
    for (int k = 0; k < FRAME; k++) begin
      stepCycle();
      if (k == 3)  checkOutput("midNew0", {an, seg, dp}, {4'hE, 7'h10, 1'b1});
      if (k == 11) checkOutput("midNew2", {an, seg, dp}, {4'hB, 7'h00, 1'b1});
    end

    // Reset pulse in slot 2: outputs dark next cycle, then a full dark frame.
    while ((s % FRAME) != 9) stepCycle();
    rst = 1'b1;
    stepCycle();
    checkOutput("rstNow", {an, seg, dp}, 12'hFFF);
    rst = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      stepCycle();
      checkOutput("rstDark", {an, seg, dp}, {AN_SEQ[k], 7'h7F, 1'b1});
    end

    // Randomized traffic, biased toward zeros so suppression is exercised.
    for (int it = 0; it < 40; it++) begin
      logic [3:0] r [4];
      int         n;
      for (int d = 0; d < 4; d++)
        r[d] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      applyStimulus(r[3], r[2], r[1], r[0], 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));
      if (it == 25) begin
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
      end
      n = $urandom_range(1, 24);
      for (int k = 0; k < n; k++) stepCycle();
    end
    syncFrame();
    for (int k = 0; k < FRAME; k++) stepCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
